// File: rtl/wash_phase_timer.sv
// Per-phase countdown timer for the washing-machine controller.
// Divides clk into coarse ticks, loads a mode-scaled duration for the selected
// phase and emits a one-cycle timer_done pulse when the countdown reaches zero.
module wash_phase_timer #(
    parameter int CLK_DIV = 1000,
    parameter int CNT_W   = 12,
    parameter int SOAK_T  = 20,
    parameter int WASH_T  = 40,
    parameter int RINSE_T = 30,
    parameter int SPIN_T  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             pause,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             running
);

    localparam int PS_W = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_LIGHT  = 2'b01,
        MODE_NORMAL = 2'b10,
        MODE_HEAVY  = 2'b11
    } mode_t;

    state_t          state;
    mode_t           mode_q;
    mode_t           mode_in;
    mode_t           load_mode;
    logic [1:0]      phase_q;
    logic            en_q;
    logic [PS_W-1:0] prescaler;
    logic            rising;
    logic            load;
    logic [CNT_W-1:0] load_value;

    function automatic logic [CNT_W-1:0] phase_base(input logic [1:0] ph);
        case (ph)
            2'b00:   return CNT_W'(SOAK_T);
            2'b01:   return CNT_W'(WASH_T);
            2'b10:   return CNT_W'(RINSE_T);
            default: return CNT_W'(SPIN_T);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] scale(input logic [CNT_W-1:0] base, input mode_t md);
        logic [CNT_W-1:0] half;
        half = base >> 1;
        case (md)
            MODE_LIGHT: return (half == '0) ? CNT_W'(1) : half;
            MODE_HEAVY: return base << 1;
            default:    return base;
        endcase
    endfunction

    // Mode priority decode of the raw mode inputs (heavy > normal > light, default normal).
    always_comb begin
        mode_in = MODE_NORMAL;
        if (mode3)
            mode_in = MODE_HEAVY;
        else if (mode2)
            mode_in = MODE_NORMAL;
        else if (mode1)
            mode_in = MODE_LIGHT;
    end

    // Load detection: a fresh enable latches the mode, a phase change reuses the held mode.
    always_comb begin
        rising     = timer_enable & ~en_q;
        load       = rising | (timer_enable & (phase_sel != phase_q));
        load_mode  = rising ? mode_in : mode_q;
        load_value = scale(phase_base(phase_sel), load_mode);
    end

    // Phase FSM with registered outputs; priority disable > load > pause > tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            prescaler  <= '0;
            timer_done <= 1'b0;
            running    <= 1'b0;
            mode_q     <= MODE_NORMAL;
            phase_q    <= 2'b00;
            en_q       <= 1'b0;
        end else begin
            en_q       <= timer_enable;
            timer_done <= 1'b0;
            if (!timer_enable) begin
                state     <= IDLE;
                remaining <= '0;
                prescaler <= '0;
                running   <= 1'b0;
            end else if (load) begin
                mode_q    <= load_mode;
                phase_q   <= phase_sel;
                remaining <= load_value;
                prescaler <= '0;
                // A reload while held paused stays paused with the fresh value.
                if (state == PAUSED && pause) begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                state      <= EXPIRED;
                                running    <= 1'b0;
                                timer_done <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PS_W'(1);
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: a cycle-level behavioural model
// checked against the DUT every cycle, plus directed scenarios with literal
// expectations for load values, pulse latency, pause, cancel and reset.
module tb_wash_phase_timer;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 12;
    localparam int SOAK_T  = 3;
    localparam int WASH_T  = 5;
    localparam int RINSE_T = 2;
    localparam int SPIN_T  = 1;

    logic             clk;
    logic             rst_n;
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic             mode1, mode2, mode3;
    logic             pause;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             running;

    wash_phase_timer #(
        .CLK_DIV(CLK_DIV),
        .CNT_W  (CNT_W),
        .SOAK_T (SOAK_T),
        .WASH_T (WASH_T),
        .RINSE_T(RINSE_T),
        .SPIN_T (SPIN_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timer_enable(timer_enable),
        .phase_sel   (phase_sel),
        .mode1       (mode1),
        .mode2       (mode2),
        .mode3       (mode3),
        .pause       (pause),
        .timer_done  (timer_done),
        .remaining   (remaining),
        .running     (running)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Status flags: counting, frozen (lid open) or finished; none set means idle.
    bit m_counting, m_frozen, m_finished;
    int m_rem, m_sub, m_mode, m_phase;
    bit m_en, m_done, m_prev_en;
    int base_tab[4] = '{SOAK_T, WASH_T, RINSE_T, SPIN_T};

    function automatic int duration(input int ph, input int md);
        int b;
        b = base_tab[ph];
        if (md == 0) return (b / 2 < 1) ? 1 : b / 2;
        if (md == 2) return (b * 2) % (1 << CNT_W);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_counting = 0; m_frozen = 0; m_finished = 0;
            m_rem = 0; m_sub = 0; m_mode = 1; m_phase = 0;
            m_en = 0; m_done = 0;
        end else begin
            m_prev_en = m_en;
            m_en = timer_enable;
            m_done = 0;
            if (!timer_enable) begin
                m_counting = 0; m_frozen = 0; m_finished = 0;
                m_rem = 0; m_sub = 0;
            end else if (!m_prev_en || int'(phase_sel) != m_phase) begin
                if (!m_prev_en)
                    m_mode = mode3 ? 2 : mode2 ? 1 : mode1 ? 0 : 1;
                m_phase = int'(phase_sel);
                m_rem = duration(m_phase, m_mode);
                m_sub = 0;
                m_finished = 0;
                if (m_frozen && pause) begin
                    m_counting = 0;
                end else begin
                    m_frozen = 0; m_counting = 1;
                end
            end else if (m_counting) begin
                if (pause) begin
                    m_counting = 0; m_frozen = 1;
                end else begin
                    m_sub = m_sub + 1;
                    if (m_sub == CLK_DIV) begin
                        m_sub = 0;
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_counting = 0; m_finished = 1; m_done = 1;
                        end
                    end
                end
            end else if (m_frozen && !pause) begin
                m_frozen = 0; m_counting = 1;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the edge.
    always @(posedge clk) begin
        #1;
        check("remaining", int'(remaining), m_rem);
        check("timer_done", int'(timer_done), int'(m_done));
        check("running", int'(running), int'(m_counting));
        if (timer_done) done_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int maxc, output int dcyc, output bit ok);
        ok = 0;
        dcyc = -1;
        for (int i = 0; i < maxc && !ok; i++) begin
            wait_edges(1);
            if (timer_done) begin
                ok = 1;
                dcyc = cyc;
            end
        end
    endtask

    task automatic set_mode(input bit m1, input bit m2, input bit m3);
        mode1 = m1; mode2 = m2; mode3 = m3;
    endtask

    initial begin
        int L, dc, snap;
        bit ok;
        int heavy[4] = '{6, 10, 4, 2};

        rst_n = 1'b0; timer_enable = 1'b0; phase_sel = 2'b00;
        mode1 = 0; mode2 = 0; mode3 = 0; pause = 0;
        #13;
        check("reset_remaining", int'(remaining), 0);
        check("reset_done", int'(timer_done), 0);
        check("reset_running", int'(running), 0);
        rst_n = 1'b1;
        wait_edges(2);

        // 1: SOAK normal
        set_mode(0, 1, 0); phase_sel = 2'b00; timer_enable = 1;
        snap = done_cnt;
        wait_edges(1); L = cyc;
        check("t1_load", int'(remaining), 3);
        check("t1_running", int'(running), 1);
        wait_edges(4);  check("t1_L4", int'(remaining), 2);
        wait_edges(4);  check("t1_L8", int'(remaining), 1);
        wait_edges(4);  check("t1_L12", int'(remaining), 0);
        check("t1_done_L12", int'(timer_done), 1);
        wait_edges(1);  check("t1_done_L13", int'(timer_done), 0);
        wait_edges(27);
        check("t1_pulses", done_cnt - snap, 1);
        timer_enable = 0; wait_edges(2);

        // 2: full cycle, heavy
        set_mode(0, 0, 1); phase_sel = 2'b00; timer_enable = 1;
        snap = done_cnt;
        wait_edges(1); L = cyc;
        check("t2_load0", int'(remaining), heavy[0]);
        for (int k = 0; k < 4; k++) begin
            wait_done(60, dc, ok);
            check("t2_done_seen", int'(ok), 1);
            check("t2_latency", dc - L, heavy[k] * CLK_DIV);
            if (k < 3) begin
                wait_edges(1);
                phase_sel = 2'(k + 1);
                wait_edges(1); L = cyc;
                check("t2_load", int'(remaining), heavy[k + 1]);
            end
        end
        wait_edges(20);
        check("t2_pulses", done_cnt - snap, 4);
        timer_enable = 0; wait_edges(2);

        // 3: SPIN light clamps to 1
        set_mode(1, 0, 0); phase_sel = 2'b11; timer_enable = 1;
        wait_edges(1); L = cyc;
        check("t3_load", int'(remaining), 1);
        wait_done(20, dc, ok);
        check("t3_done_seen", int'(ok), 1);
        check("t3_latency", dc - L, 4);
        timer_enable = 0; wait_edges(2);

        // 4: WASH normal with a 19-edge pause (20 cycles late in total)
        set_mode(0, 1, 0); phase_sel = 2'b01; timer_enable = 1;
        wait_edges(1); L = cyc;
        check("t4_load", int'(remaining), 5);
        wait_edges(5);
        check("t4_L5", int'(remaining), 4);
        pause = 1;
        wait_edges(1);
        check("t4_paused_running", int'(running), 0);
        check("t4_paused_rem", int'(remaining), 4);
        wait_edges(18);
        check("t4_hold_rem", int'(remaining), 4);
        check("t4_hold_done", int'(timer_done), 0);
        pause = 0;
        wait_done(60, dc, ok);
        check("t4_done_seen", int'(ok), 1);
        check("t4_latency", dc - L, 40);
        timer_enable = 0; wait_edges(2);

        // 5: cancel mid-WASH, then re-enable heavy and check mode is held
        set_mode(0, 1, 0); phase_sel = 2'b01; timer_enable = 1;
        snap = done_cnt;
        wait_edges(1);
        wait_edges(8);
        timer_enable = 0;
        wait_edges(1);
        check("t5_cancel_rem", int'(remaining), 0);
        check("t5_cancel_running", int'(running), 0);
        wait_edges(20);
        check("t5_no_pulse", done_cnt - snap, 0);
        set_mode(0, 0, 1); timer_enable = 1;
        wait_edges(1);
        check("t5_heavy", int'(remaining), 10);
        set_mode(1, 0, 0);
        wait_edges(3);
        phase_sel = 2'b00;
        wait_edges(1);
        check("t5_mode_held", int'(remaining), 6);
        timer_enable = 0; wait_edges(2);

        // 6: asynchronous reset during RUN
        set_mode(0, 1, 0); phase_sel = 2'b00; timer_enable = 1;
        snap = done_cnt;
        wait_edges(1);
        check("t6_load", int'(remaining), 3);
        wait_edges(2);
        #1 rst_n = 0;
        #1;
        check("t6_rst_rem", int'(remaining), 0);
        check("t6_rst_done", int'(timer_done), 0);
        check("t6_rst_running", int'(running), 0);
        timer_enable = 0;
        wait_edges(2);
        rst_n = 1;
        wait_edges(10);
        check("t6_quiet_rem", int'(remaining), 0);
        check("t6_quiet_running", int'(running), 0);
        check("t6_no_pulse", done_cnt - snap, 0);
        timer_enable = 1;
        wait_edges(1);
        check("t6_reload", int'(remaining), 3);
        check("t6_reload_running", int'(running), 1);
        timer_enable = 0; wait_edges(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
